pc_sequencer: RTL
=================

# pc_sequencer

Multi-cycle fetch/sequence controller that drives the PC register's `PCWre` and `PCData` inputs. It steps each instruction through IF/ID/EXE/MEM/WB according to a pre-decoded operation class. In the instruction's final state it asserts `PCWre` for exactly one cycle and presents the next address: sequential, branch, jump or register-indirect.

## Interface
- `RESET_PC`, default 32'h0000_0000, value driven on `PCData` while idle in reset.
- `CLK`  in  1  system clock; state advances on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current instruction address from the PC register; constant for the whole instruction.
- `op_class`  in  3  pre-decoded class from the IR; stable from ID until the instruction completes.
- `zero`  in  1  ALU zero flag; valid in EXE.
- `branch_ne`  in  1  1 = bne, 0 = beq.
- `imm16`  in  16  branch offset in words, signed.
- `jaddr`  in  26  jump field.
- `rs_data`  in  32  jr target.
- `mem_ready`  in  1  memory done; present only with `PC_SEQ_MEMWAIT_EN`.
- `PCWre`  out  1  PC write enable, one-cycle pulse.
- `PCData`  out  32  next PC.
- `IRWre`  out  1  IR load strobe in IF.
- `state`  out  3  current state, for debug and other control.
- `halted`  out  1  high in HALT.

## Operation
- op_class codes:
  - 0 ALU
  - 1 LOAD
  - 2 STORE
  - 3 BRANCH
  - 4 JUMP
  - 5 JAL
  - 6 JR
  - 7 HALT
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to IF on the next edge.
- Paths:
  - JUMP/JAL/JR: IF→ID→IF.
  - HALT: IF→ID→HALT.
  - BRANCH: IF→ID→EXE→IF.
  - ALU: IF→ID→EXE→WB→IF.
  - STORE: IF→ID→EXE→MEM→IF.
  - LOAD: IF→ID→EXE→MEM→WB→IF.
- `PCWre`=1 only in the final state of a path: ID for jumps, EXE for BRANCH, MEM for STORE, WB for ALU/LOAD. It is 0 everywhere else, including HALT.
- `PCData` (all arithmetic modulo 2^32):
  - Sequential: pc+4.
  - BRANCH: taken = zero XOR branch_ne. Taken gives pc+4+(sext(imm16)<<2); not taken gives pc+4.
  - JUMP/JAL: {pc_plus4[31:28], jaddr, 2'b00}.
  - JR: rs_data.
  - Outside a `PCWre` cycle: pc+4.
- Link-register write for JAL is owned elsewhere.
- `IRWre`=1 in IF.
- `halted`=1 in HALT. HALT is left only via `Reset`.

## Timing
- State register: posedge `CLK`. `PCWre`, `PCData`, `IRWre` and `halted` are combinational from state and inputs. The PC register captures on the falling edge of the same cycle.
- Latency from IF entry to the `PCWre` cycle:
  - jumps: 2 cycles
  - branch: 3 cycles
  - ALU and STORE: 4 cycles
  - LOAD: 5 cycles
- Reset asserted: state=IF immediately (asynchronous); `PCWre`=0, `IRWre`=0, `halted`=0, `PCData`=`RESET_PC`, all forced while `Reset`=1. First IF cycle begins on the first rising edge after deassertion.
- Reset mid-instruction: the instruction is abandoned; no `PCWre` pulse.
- pc=0xFFFF_FFFC sequential next is 0x0000_0000. Branch target wraps identically.

## Configuration
- `PC_SEQ_MEMWAIT_EN` defined:
  - `mem_ready` port exists.
  - IF holds with `IRWre`=0 until `mem_ready`=1, then asserts `IRWre` and advances.
  - MEM holds until `mem_ready`=1; STORE's `PCWre` is gated by `mem_ready`.
- Undefined: no `mem_ready` port; IF and MEM always take one cycle.

## Structure
- `pc_seq_pkg` holds:
  - state localparams
  - op_class codes
  - `PC_STEP`=4
- Sub-module `pc_target`: purely combinational next-address mux and adders (pc+4, branch target, jump concat, jr select).

## Test plan
- Reset held, then released; pc=0, ALU stream → `IRWre` in cycle 1; `PCWre`=1 only in cycle 4 with `PCData`=0x4; repeat period 4.
- pc=0x10, BRANCH, imm16=0xFFFE, zero=1, branch_ne=0 → cycle-3 `PCData`=0x0C. Same with branch_ne=1 → 0x14.
- pc=0x4000_0008, JUMP, jaddr=0x10 → cycle-2 `PCWre`=1, `PCData`=0x4000_0040. JR with rs_data=0x1234 → 0x1234.
- pc=0xFFFF_FFFC, LOAD → `PCWre` only in cycle 5, `PCData`=0x0.
- HALT → `halted`=1, `PCWre` stays 0 for 20 cycles. `Reset` mid-EXE of a BRANCH → no `PCWre`, state=IF immediately.
- With `PC_SEQ_MEMWAIT_EN`: STORE, `mem_ready` low for 3 MEM cycles → `PCWre` only on the cycle `mem_ready`=1, total 7 cycles.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the multi-cycle PC sequencer: state codes, op_class codes, PC step.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;
    localparam logic [2:0] OP_JAL    = 3'd5;
    localparam logic [2:0] OP_JR     = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_target.sv
// Combinational next-address selection: pc+4, branch target, jump concat, jr register.
module pc_target
    import pc_seq_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_op_class,
    input  logic        i_zero,
    input  logic        i_branch_ne,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_jaddr,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_target
);

    logic signed [31:0] w_offset;
    logic [31:0]        w_branch_tgt;
    logic               w_taken;

    assign o_pc_plus4   = i_pc + PC_STEP;
    assign w_offset     = {{14{i_imm16[15]}}, i_imm16, 2'b00};
    assign w_branch_tgt = o_pc_plus4 + $unsigned(w_offset);
    assign w_taken      = i_zero ^ i_branch_ne;

    always_comb begin
        o_target = o_pc_plus4;
        case (i_op_class)
            OP_BRANCH: o_target = w_taken ? w_branch_tgt : o_pc_plus4;
            OP_JUMP,
            OP_JAL:    o_target = {o_pc_plus4[31:28], i_jaddr, 2'b00};
            OP_JR:     o_target = i_rs_data;
            default:   o_target = o_pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer issuing a one-cycle PCWre with the next PC.
// Optional memory handshake on IF and MEM is enabled by defining PC_SEQ_MEMWAIT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] pc,
    input  logic [2:0]  op_class,
    input  logic        zero,
    input  logic        branch_ne,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
`ifdef PC_SEQ_MEMWAIT_EN
    input  logic        mem_ready,
`endif
    output logic        PCWre,
    output logic [31:0] PCData,
    output logic        IRWre,
    output logic [2:0]  state,
    output logic        halted
);

    state_t      r_state;
    state_t      w_next;
    logic        r_run;
    logic        w_mem_ok;
    logic        w_pcwre;
    logic        w_is_jump;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

`ifdef PC_SEQ_MEMWAIT_EN
    assign w_mem_ok = mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    assign w_is_jump = (op_class == OP_JUMP) || (op_class == OP_JAL) || (op_class == OP_JR);

    pc_target u_pc_target (
        .i_pc        (pc),
        .i_op_class  (op_class),
        .i_zero      (zero),
        .i_branch_ne (branch_ne),
        .i_imm16     (imm16),
        .i_jaddr     (jaddr),
        .i_rs_data   (rs_data),
        .o_pc_plus4  (w_pc_plus4),
        .o_target    (w_target)
    );

    // r_run keeps the sequencer parked in IF until the first edge after reset release.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_run   <= 1'b0;
            r_state <= ST_IF;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = ST_IF;
        w_pcwre = 1'b0;
        case (r_state)
            ST_IF: begin
                w_next = (r_run && w_mem_ok) ? ST_ID : ST_IF;
            end
            ST_ID: begin
                if (w_is_jump) begin
                    w_next  = ST_IF;
                    w_pcwre = 1'b1;
                end else if (op_class == OP_HALT) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_EXE;
                end
            end
            ST_EXE: begin
                case (op_class)
                    OP_BRANCH: begin
                        w_next  = ST_IF;
                        w_pcwre = 1'b1;
                    end
                    OP_ALU:   w_next = ST_WB;
                    OP_LOAD,
                    OP_STORE: w_next = ST_MEM;
                    default:  w_next = ST_IF;
                endcase
            end
            ST_MEM: begin
                if (!w_mem_ok) begin
                    w_next = ST_MEM;
                end else if (op_class == OP_LOAD) begin
                    w_next = ST_WB;
                end else begin
                    w_next  = ST_IF;
                    w_pcwre = (op_class == OP_STORE);
                end
            end
            ST_WB: begin
                w_next  = ST_IF;
                w_pcwre = 1'b1;
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IF;
        endcase
    end

    assign state  = r_state;
    assign PCWre  = w_pcwre && !Reset;
    assign IRWre  = (r_state == ST_IF) && r_run && w_mem_ok && !Reset;
    assign halted = (r_state == ST_HALT) && !Reset;
    assign PCData = (Reset || !r_run) ? RESET_PC : (PCWre ? w_target : w_pc_plus4);

endmodule
